gpio_control_mux: RTL and testbench
===================================

Name: gpio_control_mux

Overview:
- Per-pin GPIO ownership multiplexer for the 38 user I/O pins shared by 13 project slots.
- Each pin has its own 4-bit select. The select picks which project's io_out/io_oeb bit drives that pin.
- Sits between the project wrappers and the user I/O pads. Select lines come from the configuration registers.
- Datapath is combinational by default, with an optional output register stage.

Parameters:
- NUM_PROJ, 13, number of project slots (select values 0..NUM_PROJ-1 are valid).
- NUM_PINS, 38, number of GPIO pins; fixed split into groups 0-7, 8-15, 16-23, 24-31, 32-37.
- SEL_W, 4, width of each per-pin select.

Ports:
- clk  input  1  system clock; used only when the output register is enabled.
- nrst  input  1  asynchronous reset, ACTIVE-HIGH (1 = reset asserted) despite the name.
- io_oeb  input  [NUM_PINS-1:0] x NUM_PROJ (unpacked array)  per-project output-enable-bar; 1 = pin is an input / not driven.
- io_out  input  [NUM_PINS-1:0] x NUM_PROJ (unpacked array)  per-project output data.
- pin_0to7_sel  input  [SEL_W-1:0] x 8  selects for pins 0-7; element k maps to pin k.
- pin_8to15_sel  input  [SEL_W-1:0] x 8  selects for pins 8-15; element k maps to pin 8+k.
- pin_16to23_sel  input  [SEL_W-1:0] x 8  selects for pins 16-23; element k maps to pin 16+k.
- pin_24to31_sel  input  [SEL_W-1:0] x 8  selects for pins 24-31; element k maps to pin 24+k.
- pin_32to37_sel  input  [SEL_W-1:0] x 6  selects for pins 32-37; element k maps to pin 32+k.
- muxxed_io_oeb  output  [NUM_PINS-1:0]  muxed output-enable-bar to the pads.
- muxxed_io_out  output  [NUM_PINS-1:0]  muxed output data to the pads.

Behaviour:
- Pin mapping: for each pin p with select s = sel(p):
  - muxxed_io_oeb[p] = io_oeb[s][p]
  - muxxed_io_out[p] = io_out[s][p]
- Bit position is preserved: pin p always takes bit p of the chosen project, never another bit index.
- Out-of-range select (s >= NUM_PROJ, i.e. 13-15): pin goes to the safe state, oeb=1 and out=0.
- Reset: while nrst=1, all outputs are forced asynchronously to safe state: muxxed_io_oeb = all ones, muxxed_io_out = all zeros. Reset overrides everything, including mid-operation. Release is glitch-free.
- Default build (no macro):
  - Outputs are purely combinational from io_*, selects and nrst; zero-cycle latency.
  - clk is unused.
  - A change in any input must be visible on the outputs within the same cycle, before the next clk edge.
- Pins are fully independent: any number of pins may select the same project, and any project may own any subset of pins.
- No handshake and no state machine.

Optional Feature:
- Macro: GPIO_CONTROL_OUTPUT_REG_EN.
- When defined:
  - Both muxed outputs are registered on posedge clk, giving exactly 1-cycle latency from input/select change to the outputs.
  - The flops reset asynchronously on nrst=1 to oeb = all ones and out = all zeros, and hold that value until the first posedge after release.
  - Out-of-range select rule still applies, before the register.
- When undefined: combinational behaviour as above.

Test Plan:
- Reset: nrst=1 with arbitrary inputs -> muxxed_io_oeb=38'h3F_FFFF_FFFF and muxxed_io_out=0, asserted asynchronously without waiting for a clk edge.
- All selects 0; io_out[0]=38'h2A_AAAA_AAAA, io_oeb[0]=38'h15_5555_5555, other projects all ones -> outputs equal project 0 values exactly.
- Pin-boundary walk: pin 7 sel=12, pin 8 sel=1, pin 31 sel=5, pin 37 sel=12, other pins sel=0. Project data is one-hot per project (io_out[n] = ones only in its owned pins) -> each pin shows its owner's bit. Confirms group indexing at 7/8, 31/32 and 37.
- Out-of-range: pin 3 sel=13, pin 20 sel=15 -> those pins oeb=1, out=0; all other pins unaffected.
- Random regression: 60 iterations of random io_out/io_oeb (13x38) and random selects 0..12 -> every pin p matches io_*[sel(p)][p] at the check point: same cycle without the macro, next posedge with GPIO_CONTROL_OUTPUT_REG_EN.
- Reset mid-run: assert nrst during random traffic -> outputs snap to safe state. After release they follow the mux again (registered build: from the first posedge after release).

Source files
------------

// File: rtl/gpio_control_mux.sv
// gpio_control_mux
// Per-pin GPIO ownership multiplexer: each of the NUM_PINS user I/O pins picks
// one of NUM_PROJ project slots through its own SEL_W-bit select. Pin p always
// takes bit p of the chosen project. Selects outside 0..NUM_PROJ-1 park the pin
// in the safe state (oeb=1, out=0), as does reset (nrst, active-high).
//
// Build option: define GPIO_CONTROL_OUTPUT_REG_EN to register both muxed
// outputs on posedge clk (1-cycle latency). Without it the datapath is purely
// combinational and clk is unused.

module gpio_control_mux #(
    parameter int NUM_PROJ = 13,
    parameter int NUM_PINS = 38,
    parameter int SEL_W    = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_PINS-1:0] io_oeb [NUM_PROJ],
    input  logic [NUM_PINS-1:0] io_out [NUM_PROJ],
    input  logic [SEL_W-1:0]    pin_0to7_sel   [8],
    input  logic [SEL_W-1:0]    pin_8to15_sel  [8],
    input  logic [SEL_W-1:0]    pin_16to23_sel [8],
    input  logic [SEL_W-1:0]    pin_24to31_sel [8],
    input  logic [SEL_W-1:0]    pin_32to37_sel [6],
    output logic [NUM_PINS-1:0] muxxed_io_oeb,
    output logic [NUM_PINS-1:0] muxxed_io_out
);

    // Safe pad state: not driven, data low.
    localparam logic [NUM_PINS-1:0] SAFE_OEB = {NUM_PINS{1'b1}};
    localparam logic [NUM_PINS-1:0] SAFE_OUT = {NUM_PINS{1'b0}};

    // Returns {oeb, out} for one pin given its select and the per-project
    // bits already restricted to this pin's bit position.
    function automatic logic [1:0] pin_pick(
        input logic [SEL_W-1:0]    sel,
        input logic [NUM_PROJ-1:0] oeb_col,
        input logic [NUM_PROJ-1:0] out_col
    );
        logic [1:0] res;
        if (sel < SEL_W'(NUM_PROJ)) begin
            res = {oeb_col[sel], out_col[sel]};
        end else begin
            res = 2'b10;
        end
        return res;
    endfunction

    logic [SEL_W-1:0]    pin_sel_s  [NUM_PINS];
    logic [NUM_PROJ-1:0] oeb_col_s  [NUM_PINS];
    logic [NUM_PROJ-1:0] out_col_s  [NUM_PINS];
    logic [NUM_PINS-1:0] mux_oeb_s;
    logic [NUM_PINS-1:0] mux_out_s;
    logic [1:0]          pick_s     [NUM_PINS];

    // Flatten the five select groups into one per-pin select table.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            pin_sel_s[p] = {SEL_W{1'b1}};
        end
        for (int k = 0; k < 8; k++) begin
            pin_sel_s[k]      = pin_0to7_sel[k];
            pin_sel_s[8 + k]  = pin_8to15_sel[k];
            pin_sel_s[16 + k] = pin_16to23_sel[k];
            pin_sel_s[24 + k] = pin_24to31_sel[k];
        end
        for (int k = 0; k < 6; k++) begin
            pin_sel_s[32 + k] = pin_32to37_sel[k];
        end
    end

    // Transpose project buses so each pin sees only its own bit of every project.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            oeb_col_s[p] = {NUM_PROJ{1'b1}};
            out_col_s[p] = {NUM_PROJ{1'b0}};
            for (int j = 0; j < NUM_PROJ; j++) begin
                oeb_col_s[p][j] = io_oeb[j][p];
                out_col_s[p][j] = io_out[j][p];
            end
        end
    end

    // Per-pin selection; invalid selects resolve to the safe state.
    always_comb begin
        mux_oeb_s = SAFE_OEB;
        mux_out_s = SAFE_OUT;
        for (int p = 0; p < NUM_PINS; p++) begin
            pick_s[p]    = pin_pick(pin_sel_s[p], oeb_col_s[p], out_col_s[p]);
            mux_oeb_s[p] = pick_s[p][1];
            mux_out_s[p] = pick_s[p][0];
        end
    end

`ifdef GPIO_CONTROL_OUTPUT_REG_EN

    logic [NUM_PINS-1:0] muxxed_io_oeb_d;
    logic [NUM_PINS-1:0] muxxed_io_out_d;
    logic [NUM_PINS-1:0] muxxed_io_oeb_q;
    logic [NUM_PINS-1:0] muxxed_io_out_q;

    // Next-state for the output register is simply the mux result.
    always_comb begin
        muxxed_io_oeb_d = mux_oeb_s;
        muxxed_io_out_d = mux_out_s;
    end

    // Output register; reset parks the pads until the first edge after release.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            muxxed_io_oeb_q <= SAFE_OEB;
            muxxed_io_out_q <= SAFE_OUT;
        end else begin
            muxxed_io_oeb_q <= muxxed_io_oeb_d;
            muxxed_io_out_q <= muxxed_io_out_d;
        end
    end

    assign muxxed_io_oeb = muxxed_io_oeb_q;
    assign muxxed_io_out = muxxed_io_out_q;

`else

    // clk only matters for the registered build.
    logic unused_clk_s;
    assign unused_clk_s = clk;

    // Combinational output; reset overrides the mux without waiting for a clock.
    always_comb begin
        if (nrst) begin
            muxxed_io_oeb = SAFE_OEB;
            muxxed_io_out = SAFE_OUT;
        end else begin
            muxxed_io_oeb = mux_oeb_s;
            muxxed_io_out = mux_out_s;
        end
    end

`endif

endmodule

// File: tb/tb_gpio_control_mux.sv
// Self-checking bench for gpio_control_mux: directed vectors with hand-computed
// expectations plus a random regression against a small reference model.
// Works with or without GPIO_CONTROL_OUTPUT_REG_EN defined.

module tb_gpio_control_mux;

    localparam int NUM_PROJ = 13;
    localparam int NUM_PINS = 38;
    localparam int SEL_W    = 4;

    logic                clk;
    logic                nrst;
    logic [NUM_PINS-1:0] io_oeb [NUM_PROJ];
    logic [NUM_PINS-1:0] io_out [NUM_PROJ];
    logic [SEL_W-1:0]    pin_0to7_sel   [8];
    logic [SEL_W-1:0]    pin_8to15_sel  [8];
    logic [SEL_W-1:0]    pin_16to23_sel [8];
    logic [SEL_W-1:0]    pin_24to31_sel [8];
    logic [SEL_W-1:0]    pin_32to37_sel [6];
    logic [NUM_PINS-1:0] muxxed_io_oeb;
    logic [NUM_PINS-1:0] muxxed_io_out;

    logic [SEL_W-1:0]    tb_sel [NUM_PINS];
    logic [NUM_PINS-1:0] exp_oeb;
    logic [NUM_PINS-1:0] exp_out;
    int                  n_cmp;
    int                  n_err;

    gpio_control_mux #(
        .NUM_PROJ(NUM_PROJ),
        .NUM_PINS(NUM_PINS),
        .SEL_W   (SEL_W)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .io_oeb        (io_oeb),
        .io_out        (io_out),
        .pin_0to7_sel  (pin_0to7_sel),
        .pin_8to15_sel (pin_8to15_sel),
        .pin_16to23_sel(pin_16to23_sel),
        .pin_24to31_sel(pin_24to31_sel),
        .pin_32to37_sel(pin_32to37_sel),
        .muxxed_io_oeb (muxxed_io_oeb),
        .muxxed_io_out (muxxed_io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [NUM_PINS-1:0] got,
                            input logic [NUM_PINS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push the bench's per-pin select table onto the grouped ports.
    task automatic apply_sel();
        for (int k = 0; k < 8; k++) begin
            pin_0to7_sel[k]   = tb_sel[k];
            pin_8to15_sel[k]  = tb_sel[8 + k];
            pin_16to23_sel[k] = tb_sel[16 + k];
            pin_24to31_sel[k] = tb_sel[24 + k];
        end
        for (int k = 0; k < 6; k++) begin
            pin_32to37_sel[k] = tb_sel[32 + k];
        end
    endtask

    task automatic set_all_sel(input logic [SEL_W-1:0] s);
        for (int p = 0; p < NUM_PINS; p++) tb_sel[p] = s;
    endtask

    // Wait until a new input set is visible on the outputs.
    task automatic settle();
`ifdef GPIO_CONTROL_OUTPUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Reference: pin p takes bit p of the selected project, or safe if invalid.
    task automatic model();
        for (int p = 0; p < NUM_PINS; p++) begin
            if (int'(tb_sel[p]) >= NUM_PROJ) begin
                exp_oeb[p] = 1'b1;
                exp_out[p] = 1'b0;
            end else begin
                exp_oeb[p] = io_oeb[int'(tb_sel[p])][p];
                exp_out[p] = io_out[int'(tb_sel[p])][p];
            end
        end
    endtask

    task automatic randomize_io();
        for (int j = 0; j < NUM_PROJ; j++) begin
            io_out[j] = {6'($urandom()), $urandom()};
            io_oeb[j] = {6'($urandom()), $urandom()};
        end
        for (int p = 0; p < NUM_PINS; p++) tb_sel[p] = 4'($urandom_range(12, 0));
        apply_sel();
    endtask

    logic [NUM_PINS-1:0] owner_exp [4];
    int                  owner_id  [4];

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset with arbitrary inputs, before any clock edge.
        nrst = 1'b1;
        randomize_io();
        #3;
        check_eq("reset_oeb", muxxed_io_oeb, 38'h3F_FFFF_FFFF);
        check_eq("reset_out", muxxed_io_out, 38'h00_0000_0000);

        // All selects 0, project 0 patterned, others all ones.
        for (int j = 0; j < NUM_PROJ; j++) begin
            io_out[j] = {NUM_PINS{1'b1}};
            io_oeb[j] = {NUM_PINS{1'b1}};
        end
        io_out[0] = 38'h2A_AAAA_AAAA;
        io_oeb[0] = 38'h15_5555_5555;
        set_all_sel(4'd0);
        apply_sel();
        @(negedge clk);
        nrst = 1'b0;
        settle();
        check_eq("sel0_oeb", muxxed_io_oeb, 38'h15_5555_5555);
        check_eq("sel0_out", muxxed_io_out, 38'h2A_AAAA_AAAA);

        // Pin-boundary walk: owners 12 (pins 7,37), 1 (pin 8), 5 (pin 31), 0 (rest).
        set_all_sel(4'd0);
        tb_sel[7]  = 4'd12;
        tb_sel[8]  = 4'd1;
        tb_sel[31] = 4'd5;
        tb_sel[37] = 4'd12;
        apply_sel();
        for (int j = 0; j < NUM_PROJ; j++) begin
            io_out[j] = {NUM_PINS{1'b0}};
            io_oeb[j] = {NUM_PINS{1'b1}};
        end
        io_out[0]  = 38'h1F_7FFF_FE7F;
        io_out[1]  = 38'h00_0000_0100;
        io_out[5]  = 38'h00_8000_0000;
        io_out[12] = 38'h20_0000_0080;
        io_oeb[12] = {NUM_PINS{1'b0}};
        settle();
        check_eq("walk_out", muxxed_io_out, 38'h3F_FFFF_FFFF);
        check_eq("walk_oeb", muxxed_io_oeb, 38'h1F_FFFF_FF7F);

        // One owner at a time drives all ones; only its pins may go high.
        owner_id[0] = 0;  owner_exp[0] = 38'h1F_7FFF_FE7F;
        owner_id[1] = 1;  owner_exp[1] = 38'h00_0000_0100;
        owner_id[2] = 5;  owner_exp[2] = 38'h00_8000_0000;
        owner_id[3] = 12; owner_exp[3] = 38'h20_0000_0080;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NUM_PROJ; j++) io_out[j] = {NUM_PINS{1'b0}};
            io_out[owner_id[i]] = {NUM_PINS{1'b1}};
            settle();
            check_eq($sformatf("owner%0d_out", owner_id[i]), muxxed_io_out, owner_exp[i]);
        end

        // Out-of-range selects 13, 14, 15 park their pins; others untouched.
        for (int j = 0; j < NUM_PROJ; j++) begin
            io_out[j] = {NUM_PINS{1'b1}};
            io_oeb[j] = {NUM_PINS{1'b0}};
        end
        set_all_sel(4'd0);
        tb_sel[3]  = 4'd13;
        tb_sel[20] = 4'd15;
        tb_sel[37] = 4'd14;
        apply_sel();
        settle();
        check_eq("oor_out", muxxed_io_out, 38'h1F_FFEF_FFF7);
        check_eq("oor_oeb", muxxed_io_oeb, 38'h20_0010_0008);

        // Random regression against the reference model.
        for (int it = 0; it < 60; it++) begin
            randomize_io();
            model();
            settle();
            check_eq($sformatf("rnd%0d_oeb", it), muxxed_io_oeb, exp_oeb);
            check_eq($sformatf("rnd%0d_out", it), muxxed_io_out, exp_out);
        end

        // Reset mid-run: asynchronous snap to safe state, then follow again.
        randomize_io();
        #2;
        nrst = 1'b1;
        #1;
        check_eq("midrst_oeb", muxxed_io_oeb, 38'h3F_FFFF_FFFF);
        check_eq("midrst_out", muxxed_io_out, 38'h00_0000_0000);
        randomize_io();
        #1;
        check_eq("midrst_hold_oeb", muxxed_io_oeb, 38'h3F_FFFF_FFFF);
        check_eq("midrst_hold_out", muxxed_io_out, 38'h00_0000_0000);
        @(negedge clk);
        nrst = 1'b0;
        model();
        settle();
        check_eq("post_rst_oeb", muxxed_io_oeb, exp_oeb);
        check_eq("post_rst_out", muxxed_io_out, exp_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
